// File: rtl/spi_regs_pkg.sv
// Shared constants and FSM encoding for the SPI command decoder
// and its register bank.
package spi_regs_pkg;

    localparam int REG_LED     = 0;
    localparam int REG_SCRATCH = 1;
    localparam int REG_FCNT    = 2;
    localparam int REG_ID      = 3;

    localparam int CMD_RD_BIT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD
    } state_e;

endpackage

// File: rtl/spi_regfile.sv
// Register bank: LED/scratch storage, read-only frame counter and ID,
// one write port and one combinational read port.
module spi_regfile
    import spi_regs_pkg::*;
#(
    parameter int          NREGS    = 8,
    parameter int          ADDR_W   = 3,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic [7:0]        fcnt_i,
    output logic [7:0]        rdata_o,
    output logic [4:0]        led_o
);

    logic [7:0] regs_q [NREGS];
    logic       wr_ro;

    assign wr_ro = (waddr_i == ADDR_W'(REG_FCNT)) ||
                   (waddr_i == ADDR_W'(REG_ID));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && !wr_ro) begin
            // LED register keeps only the five LED bits
            if (waddr_i == ADDR_W'(REG_LED)) begin
                regs_q[waddr_i] <= {3'b000, wdata_i[4:0]};
            end else begin
                regs_q[waddr_i] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = regs_q[raddr_i];
        case (raddr_i)
            ADDR_W'(REG_FCNT): rdata_o = fcnt_i;
            ADDR_W'(REG_ID):   rdata_o = ID_VALUE;
            default:           rdata_o = regs_q[raddr_i];
        endcase
    end

    assign led_o = regs_q[REG_LED][4:0];

endmodule

// File: rtl/spi_cmd_regs.sv
// SPI command decoder: frame FSM, auto-increment address, frame counter
// and the registered MISO byte, around the spi_regfile bank.
module spi_cmd_regs
    import spi_regs_pkg::*;
#(
    parameter int          NREGS    = 8,
    parameter int          ADDR_W   = 3,
    parameter logic [7:0]  ID_VALUE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       frame_end,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic [4:0] led,
    output logic       busy
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              bad_q;
    logic [7:0]        fcnt_q;
    logic [7:0]        tx_q;
    logic              busy_q;

    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_bad;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rdata;
    logic              we;
    logic              had_byte;

    assign cmd_addr = rx_data[ADDR_W-1:0];
    assign cmd_bad  = (rx_data[6:0] >> ADDR_W) != 7'd0;
    assign addr_inc = addr_q + ADDR_W'(1);
    // Command cycle looks up the new start address, RD looks one ahead
    assign rd_addr  = (state_q == ST_CMD) ? cmd_addr : addr_inc;
    assign we       = (state_q == ST_WR) && rx_valid &&
                      !bad_q && !frame_start;
    assign had_byte = (state_q == ST_WR) || (state_q == ST_RD) ||
                      ((state_q == ST_CMD) && rx_valid);

    spi_regfile #(
        .NREGS    (NREGS),
        .ADDR_W   (ADDR_W),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (addr_q),
        .wdata_i (rx_data),
        .raddr_i (rd_addr),
        .fcnt_i  (fcnt_q),
        .rdata_o (rdata),
        .led_o   (led)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            bad_q   <= 1'b0;
            fcnt_q  <= 8'h00;
            tx_q    <= 8'h00;
            busy_q  <= 1'b0;
        end else if (frame_start) begin
            // Also aborts any open frame without counting it
            state_q <= ST_CMD;
            bad_q   <= 1'b0;
            tx_q    <= 8'h00;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_CMD: begin
                    if (rx_valid) begin
                        addr_q <= cmd_addr;
                        bad_q  <= cmd_bad;
                        if (rx_data[CMD_RD_BIT]) begin
                            state_q <= ST_RD;
                            tx_q    <= cmd_bad ? 8'h00 : rdata;
                        end else begin
                            state_q <= ST_WR;
                            tx_q    <= 8'h00;
                        end
                    end
                end
                ST_WR: begin
                    if (rx_valid) begin
                        addr_q <= addr_inc;
                    end
                end
                ST_RD: begin
                    if (rx_valid) begin
                        addr_q <= addr_inc;
                        tx_q   <= bad_q ? 8'h00 : rdata;
                    end
                end
                default: begin
                end
            endcase
            if (frame_end) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                if (had_byte) begin
                    fcnt_q <= fcnt_q + 8'd1;
                end
            end
        end
    end

    assign tx_data = tx_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_spi_cmd_regs.sv
// Directed bench for spi_cmd_regs: drives frames at the falling edge
// and checks outputs after each rising edge has been processed.
module tb_spi_cmd_regs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       frame_end;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic [4:0] led;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] rst_exp [8] = '{8'h00, 8'h00, 8'h00, 8'hA5,
                                8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    spi_cmd_regs dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_data     (tx_data),
        .led         (led),
        .busy        (busy)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fstart();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic fend();
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        frame_end = 1'b0;
    endtask

    task automatic sbyte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic sbyte_end(input logic [7:0] b);
        @(negedge clk);
        rx_valid  = 1'b1;
        frame_end = 1'b1;
        rx_data   = b;
        @(negedge clk);
        rx_valid  = 1'b0;
        frame_end = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_led", {3'b000, led}, 8'h00);
        chk("rst_tx", tx_data, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        rst_n = 1'b1;

        // read back all registers after reset
        fstart();
        chk("start_busy", {7'b0, busy}, 8'h01);
        chk("start_tx", tx_data, 8'h00);
        for (int i = 0; i < 8; i++) begin
            sbyte(i == 0 ? 8'h80 : 8'hFF);
            chk("rst_rd", tx_data, rst_exp[i]);
        end
        fend();
        chk("end_busy", {7'b0, busy}, 8'h00);

        // write 00 15 AA with latency check on the LED
        fstart();
        sbyte(8'h00);
        chk("wr_tx0", tx_data, 8'h00);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h15;
        chk("led_pre", {3'b000, led}, 8'h00);
        @(negedge clk);
        rx_valid = 1'b0;
        chk("led_post", {3'b000, led}, 8'h15);
        sbyte(8'hAA);
        fend();

        fstart();
        sbyte(8'h80);
        chk("rd_r0", tx_data, 8'h15);
        sbyte(8'h00);
        chk("rd_r1", tx_data, 8'hAA);
        sbyte(8'h00);
        chk("rd_fcnt2", tx_data, 8'h02);
        fend();

        // address wrap 7 -> 0, LED mask
        fstart();
        sbyte(8'h07);
        sbyte(8'h11);
        sbyte(8'h22);
        chk("wrap_led", {3'b000, led}, 8'h02);
        chk("wr_tx_hold", tx_data, 8'h00);
        fend();

        fstart();
        sbyte(8'h87);
        chk("rd_r7", tx_data, 8'h11);
        sbyte(8'h00);
        chk("rd_wrap_r0", tx_data, 8'h02);
        fend();

        // RO write and out-of-range write
        fstart();
        sbyte(8'h03);
        sbyte(8'hFF);
        fend();
        fstart();
        sbyte(8'h09);
        sbyte(8'h55);
        fend();

        fstart();
        sbyte(8'h81);
        chk("bad_wr_r1", tx_data, 8'hAA);
        sbyte(8'h00);
        chk("rd_fcnt7", tx_data, 8'h07);
        sbyte(8'h00);
        chk("ro_id", tx_data, 8'hA5);
        fend();

        fstart();
        sbyte(8'h8A);
        chk("bad_rd0", tx_data, 8'h00);
        sbyte(8'h00);
        chk("bad_rd1", tx_data, 8'h00);
        fend();

        // abort mid-write, then a fresh write
        fstart();
        sbyte(8'h04);
        sbyte(8'h66);
        fstart();
        chk("abort_busy", {7'b0, busy}, 8'h01);
        chk("abort_tx", tx_data, 8'h00);
        sbyte(8'h01);
        sbyte(8'h33);
        fend();

        // byte coincident with frame_end
        fstart();
        sbyte(8'h02);
        sbyte_end(8'h7E);
        chk("sim_busy", {7'b0, busy}, 8'h00);
        fstart();
        sbyte_end(8'h80);
        chk("sim_cmd_tx", tx_data, 8'h02);

        // empty frame is not counted
        fstart();
        fend();

        fstart();
        sbyte(8'h81);
        chk("abort_r1", tx_data, 8'h33);
        sbyte(8'h00);
        chk("rd_fcnt12", tx_data, 8'h0C);
        sbyte(8'h00);
        chk("rd_id2", tx_data, 8'hA5);
        sbyte(8'h00);
        chk("abort_r4", tx_data, 8'h66);
        fend();

        // reset in the middle of a read frame
        fstart();
        sbyte(8'h80);
        sbyte(8'h00);
        chk("pre_rst_tx", tx_data, 8'h33);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", tx_data, 8'h00);
        chk("mid_rst_led", {3'b000, led}, 8'h00);
        chk("mid_rst_busy", {7'b0, busy}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        sbyte(8'h81);
        chk("stray_tx", tx_data, 8'h00);
        chk("stray_busy", {7'b0, busy}, 8'h00);

        fstart();
        for (int i = 0; i < 8; i++) begin
            sbyte(i == 0 ? 8'h80 : 8'hFF);
            chk("post_rst_rd", tx_data, rst_exp[i]);
        end
        fend();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
